// File: rtl/circle_pkg.sv
// Shared state encodings and width helpers for the point-in-circle tester.
package circle_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SQX    = 3'd1;
   localparam logic [2:0] ST_SQY    = 3'd2;
   localparam logic [2:0] ST_ADDCMP = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   // Signed difference of two zero-extended coordinates
   function automatic int diff_w(input int coord_w);
      return coord_w + 1;
   endfunction

   function automatic int sq_w(input int coord_w);
      return 2 * diff_w(coord_w);
   endfunction

   function automatic int sum_w(input int coord_w);
      return sq_w(coord_w) + 1;
   endfunction

endpackage

// File: rtl/signed_square.sv
// Combinational squarer: signed DIFF_W-bit operand to unsigned SQ_W-bit square.
module signed_square #(
   parameter int DIFF_W = 11,
   parameter int SQ_W   = 2 * DIFF_W
) (
   input  logic signed [DIFF_W-1:0] d,
   output logic        [SQ_W-1:0]   sq
);

   logic signed [SQ_W-1:0] d_ext;

   assign d_ext = {{(SQ_W-DIFF_W){d[DIFF_W-1]}}, d};
   // A square is never negative and always fits SQ_W bits, so the low bits are exact
   assign sq    = d_ext * d_ext;

endmodule

// File: rtl/circle_hit_pipe.sv
// Four-cycle point-in-circle tester with one shared squarer and valid/ready handshakes.
// Define RING_MODE_EN to test against the annulus R_INNER <= r < RADIUS instead of the disc.
module circle_hit_pipe #(
   parameter int COORD_W = 10,
   parameter int CX      = 320,
   parameter int CY      = 240,
   parameter int RADIUS  = 100,
   parameter int R_INNER = 50
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [COORD_W-1:0]   x,
   input  logic [COORD_W-1:0]   y,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 hit,
   output logic [2*COORD_W+2:0] dist_sq
);
   import circle_pkg::*;

   localparam int DIFF_W = diff_w(COORD_W);
   localparam int SQ_W   = sq_w(COORD_W);
   localparam int SUM_W  = sum_w(COORD_W);

   localparam logic [DIFF_W-1:0] CX_D     = DIFF_W'(CX);
   localparam logic [DIFF_W-1:0] CY_D     = DIFF_W'(CY);
   localparam logic [SUM_W-1:0]  R_OUT_SQ = SUM_W'(RADIUS * RADIUS);

   if (CX < 0 || CY < 0 || CX >= 2**COORD_W || CY >= 2**COORD_W ||
       RADIUS <= 0 || R_INNER < 0) begin : g_bad_params
      $error("circle_hit_pipe: centre or radius out of range");
   end

   logic [2:0]               state_reg;
   logic signed [DIFF_W-1:0] dx_reg, dy_reg;
   logic [SQ_W-1:0]          sq_reg, acc_reg;
   logic [SUM_W-1:0]         dist_sq_reg;
   logic                     hit_reg;

   logic signed [DIFF_W-1:0] dx_in, dy_in, sq_operand;
   logic [SQ_W-1:0]          sq_out;
   logic [SUM_W-1:0]         sum_next;
   logic                     hit_next;
   logic                     take_input;

   assign dx_in      = $signed({1'b0, x} - CX_D);
   assign dy_in      = $signed({1'b0, y} - CY_D);
   assign in_ready   = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && out_ready);
   assign take_input = in_valid && in_ready;
   assign sq_operand = (state_reg == ST_SQY) ? dy_reg : dx_reg;
   assign sum_next   = {1'b0, acc_reg} + {1'b0, sq_reg};

`ifdef RING_MODE_EN
   localparam logic [SUM_W-1:0] R_IN_SQ = SUM_W'(R_INNER * R_INNER);

   if (R_INNER >= RADIUS) begin : g_bad_ring
      $error("circle_hit_pipe: R_INNER must be smaller than RADIUS");
   end

   assign hit_next = (sum_next >= R_IN_SQ) && (sum_next < R_OUT_SQ);
`else
   assign hit_next = (sum_next < R_OUT_SQ);
`endif

   signed_square #(.DIFF_W(DIFF_W), .SQ_W(SQ_W)) u_square (
      .d  (sq_operand),
      .sq (sq_out)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         dx_reg      <= '0;
         dy_reg      <= '0;
         sq_reg      <= '0;
         acc_reg     <= '0;
         dist_sq_reg <= '0;
         hit_reg     <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (take_input) begin
                  dx_reg    <= dx_in;
                  dy_reg    <= dy_in;
                  state_reg <= ST_SQX;
               end
            end
            ST_SQX: begin
               sq_reg    <= sq_out;
               state_reg <= ST_SQY;
            end
            ST_SQY: begin
               acc_reg   <= sq_reg;
               sq_reg    <= sq_out;
               state_reg <= ST_ADDCMP;
            end
            ST_ADDCMP: begin
               dist_sq_reg <= sum_next;
               hit_reg     <= hit_next;
               state_reg   <= ST_DONE;
            end
            ST_DONE: begin
               // Result registers hold until the next ADDCMP overwrites them
               if (out_ready) begin
                  if (in_valid) begin
                     dx_reg    <= dx_in;
                     dy_reg    <= dy_in;
                     state_reg <= ST_SQX;
                  end else begin
                     state_reg <= ST_IDLE;
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign out_valid = (state_reg == ST_DONE);
   assign hit       = hit_reg;
   assign dist_sq   = dist_sq_reg;

endmodule

// File: tb/tb_circle_hit_pipe.sv
// Self-checking bench for circle_hit_pipe: vector table, handshake corner cases, random stream.
module tb_circle_hit_pipe;

   localparam int COORD_W = 10;
   localparam int CX      = 320;
   localparam int CY      = 240;
   localparam int RADIUS  = 100;
   localparam int R_INNER = 50;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [9:0]  x = '0;
   logic [9:0]  y = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        hit;
   logic [22:0] dist_sq;

   int n_checks = 0;
   int n_pass   = 0;

   circle_hit_pipe #(
      .COORD_W (COORD_W),
      .CX      (CX),
      .CY      (CY),
      .RADIUS  (RADIUS),
      .R_INNER (R_INNER)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .hit       (hit),
      .dist_sq   (dist_sq)
   );

   always #5 clk = ~clk;

   typedef struct {
      int xi;
      int yi;
      int exp_dist;
      bit exp_disc;
      bit exp_ring;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Reference: squared Euclidean distance and region membership from plain integers
   function automatic void model(input int xi, input int yi, output int d, output bit h);
      int ddx, ddy;
      ddx = xi - CX;
      ddy = yi - CY;
      d = ddx * ddx + ddy * ddy;
`ifdef RING_MODE_EN
      h = (d >= R_INNER * R_INNER) && (d < RADIUS * RADIUS);
`else
      h = (d < RADIUS * RADIUS);
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Inputs already presented with in_ready=1: clock them in and count edges to out_valid
   task automatic accept_and_wait(output int lat);
      step();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
   endtask

   task automatic send(input int xi, input int yi, output int lat);
      int guard;
      x = 10'(xi);
      y = 10'(yi);
      in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 20) begin
         step();
         guard++;
      end
      if (!in_ready) check("in_ready_timeout", 0, 1);
      accept_and_wait(lat);
   endtask

   initial begin
      int lat, d, cycle, last_cycle, k, got;
      bit h, accepted;
      int sx[8], sy[8];
      int q_d[$];
      bit q_h[$];
      int hd;
      bit hh;
      logic [22:0] held_dist;
      logic        held_hit;

      vecs[0]  = '{320, 240, 0,       1'b1, 1'b0};
      vecs[1]  = '{420, 240, 10000,   1'b0, 1'b0};
      vecs[2]  = '{419, 240, 9801,    1'b1, 1'b1};
      vecs[3]  = '{0,   0,   160000,  1'b0, 1'b0};
      vecs[4]  = '{1023,1023,1107298, 1'b0, 1'b0};
      vecs[5]  = '{220, 240, 10000,   1'b0, 1'b0};
      vecs[6]  = '{320, 141, 9801,    1'b1, 1'b1};
      vecs[7]  = '{330, 240, 100,     1'b1, 1'b0};
      vecs[8]  = '{370, 240, 2500,    1'b1, 1'b1};
      vecs[9]  = '{369, 240, 2401,    1'b1, 1'b0};
      vecs[10] = '{320, 339, 9801,    1'b1, 1'b1};
      vecs[11] = '{250, 170, 9800,    1'b1, 1'b1};

      // Reset state
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      check("reset_out_valid", out_valid, 0);
      check("reset_hit", hit, 0);
      check("reset_dist_sq", dist_sq, 0);
      check("reset_in_ready", in_ready, 1);

      // Vector table
      for (int i = 0; i < 12; i++) begin
         send(vecs[i].xi, vecs[i].yi, lat);
         $display("vec %0d: (%0d,%0d) dist_sq=%0d hit=%0d lat=%0d",
                  i, vecs[i].xi, vecs[i].yi, dist_sq, hit, lat);
         check($sformatf("vec%0d_latency", i), lat, 4);
         check($sformatf("vec%0d_dist_sq", i), dist_sq, vecs[i].exp_dist);
`ifdef RING_MODE_EN
         check($sformatf("vec%0d_hit", i), hit, vecs[i].exp_ring);
`else
         check($sformatf("vec%0d_hit", i), hit, vecs[i].exp_disc);
`endif
      end
      step();

      // Back-pressure: hold result for 6 cycles, stray inputs ignored
      out_ready = 1'b0;
      send(300, 200, lat);
      model(300, 200, d, h);
      check("hold_latency", lat, 4);
      check("hold_dist_sq", dist_sq, d);
      held_dist = dist_sq;
      held_hit  = hit;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         x = 10'd0;
         y = 10'd0;
         #1;
         check($sformatf("hold%0d_in_ready", i), in_ready, 0);
         step();
         check($sformatf("hold%0d_out_valid", i), out_valid, 1);
         check($sformatf("hold%0d_dist_sq", i), dist_sq, held_dist);
         check($sformatf("hold%0d_hit", i), hit, held_hit);
      end
      $display("hold: dist_sq=%0d hit=%0d held 6 cycles", dist_sq, hit);
      out_ready = 1'b1;
      x = 10'd419;
      y = 10'd240;
      #1;
      check("release_in_ready", in_ready, 1);
      accept_and_wait(lat);
      model(419, 240, d, h);
      $display("release: (419,240) dist_sq=%0d hit=%0d lat=%0d", dist_sq, hit, lat);
      check("release_latency", lat, 4);
      check("release_dist_sq", dist_sq, d);
      check("release_hit", hit, h);
      step();

      // Reset while in SQY discards the transaction
      x = 10'd320;
      y = 10'd240;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midreset_in_ready", in_ready, 1);
      check("midreset_out_valid", out_valid, 0);
      got = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (out_valid) got++;
      end
      $display("midreset: %0d spurious results", got);
      check("midreset_no_result", got, 0);

      // Random back-to-back stream of 8 points
      for (int i = 0; i < 8; i++) begin
         sx[i] = CX - 130 + int'($urandom_range(0, 260));
         sy[i] = CY - 130 + int'($urandom_range(0, 260));
      end
      k = 0;
      got = 0;
      cycle = 0;
      last_cycle = 0;
      while ((k < 8 || got < 8) && cycle < 200) begin
         if (k < 8) begin
            x = 10'(sx[k]);
            y = 10'(sy[k]);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         accepted = in_valid && in_ready;
         if (accepted) begin
            model(sx[k], sy[k], hd, hh);
            q_d.push_back(hd);
            q_h.push_back(hh);
         end
         step();
         cycle++;
         if (accepted) k++;
         if (out_valid) begin
            if (q_d.size() == 0) begin
               check("stream_unexpected_result", 1, 0);
            end else begin
               hd = q_d.pop_front();
               hh = q_h.pop_front();
               $display("stream %0d: dist_sq=%0d hit=%0d cycle=%0d", got, dist_sq, hit, cycle);
               check($sformatf("stream%0d_dist_sq", got), dist_sq, hd);
               check($sformatf("stream%0d_hit", got), hit, hh);
               if (got > 0) check($sformatf("stream%0d_spacing", got), cycle - last_cycle, 4);
            end
            last_cycle = cycle;
            got++;
         end
      end
      in_valid = 1'b0;
      check("stream_result_count", got, 8);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
